// File: rtl/apb_regbank_slave.sv
// APB3 register-bank slave: NUM_REGS word registers, programmable wait states, pslverr on bad address.
// Optional byte strobes are enabled with the APB_SLV_PSTRB_EN macro.
module apb_regbank_slave #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_REGS    = 16,
    parameter int WAIT_STATES = 0
) (
    input  logic                    pclk,
    input  logic                    presetn,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [ADDR_WIDTH-1:0]   paddr,
    input  logic [DATA_WIDTH-1:0]   pwdata,
`ifdef APB_SLV_PSTRB_EN
    input  logic [DATA_WIDTH/8-1:0] pstrb,
`endif
    output logic                    pready,
    output logic [DATA_WIDTH-1:0]   prdata,
    output logic                    pslverr
);

    localparam int STRB_W    = DATA_WIDTH / 8;
    localparam int LSB       = $clog2(STRB_W);
    localparam int REG_IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(STRB_W - 1);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t                 state;
    logic [3:0]             waitCnt;
    logic                   latWrite;
    logic                   latErr;
    logic [REG_IDX_W-1:0]   latIdx;
    logic [DATA_WIDTH-1:0]  latData;
    logic [STRB_W-1:0]      latStrb;
    logic [DATA_WIDTH-1:0]  regs [NUM_REGS];

    logic [STRB_W-1:0]      capStrb;
    logic [ADDR_WIDTH-1:0]  wordAddr;
    logic [REG_IDX_W-1:0]   capIdx;
    logic                   capErr;
    logic                   setupReq;
    logic                   commitWrite;
    logic [DATA_WIDTH-1:0]  mergedWord;
    logic [DATA_WIDTH-1:0]  setupRdata;
    logic [DATA_WIDTH-1:0]  waitRdata;

`ifdef APB_SLV_PSTRB_EN
    assign capStrb = pstrb;
`else
    assign capStrb = '1;
`endif

    // The setup phase is decoded straight from the bus so that a zero-wait-state
    // transfer can raise pready in its first penable cycle; a read landing on the
    // edge where a pending write commits sees the merged word.
    always_comb begin
        wordAddr    = paddr >> LSB;
        capIdx      = REG_IDX_W'(wordAddr);
        capErr      = (|(paddr & ALIGN_MASK)) || (32'(wordAddr) >= 32'(NUM_REGS));
        setupReq    = psel && !penable;
        commitWrite = (state == DONE) && latWrite && !latErr;
        mergedWord  = regs[latIdx];
        for (int i = 0; i < STRB_W; i++) begin
            if (latStrb[i]) begin
                mergedWord[8*i +: 8] = latData[8*i +: 8];
            end
        end
        waitRdata  = (latErr || latWrite) ? '0 : regs[latIdx];
        setupRdata = '0;
        if (!capErr && !pwrite) begin
            setupRdata = (commitWrite && (capIdx == latIdx)) ? mergedWord : regs[capIdx];
        end
    end

    // Transfer FSM; the write commits on the edge that ends the pready cycle.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state    <= IDLE;
            waitCnt  <= '0;
            pready   <= 1'b0;
            prdata   <= '0;
            pslverr  <= 1'b0;
            latWrite <= 1'b0;
            latErr   <= 1'b0;
            latIdx   <= '0;
            latData  <= '0;
            latStrb  <= '0;
            for (int r = 0; r < NUM_REGS; r++) begin
                regs[r] <= '0;
            end
        end else begin
            pready  <= 1'b0;
            prdata  <= '0;
            pslverr <= 1'b0;
            if (commitWrite) begin
                regs[latIdx] <= mergedWord;
            end
            case (state)
                IDLE, DONE: begin
                    if (setupReq) begin
                        latWrite <= pwrite;
                        latErr   <= capErr;
                        latIdx   <= capIdx;
                        latData  <= pwdata;
                        latStrb  <= capStrb;
                        if (WAIT_STATES == 0) begin
                            pready  <= 1'b1;
                            prdata  <= setupRdata;
                            pslverr <= capErr;
                            state   <= DONE;
                        end else begin
                            waitCnt <= WAIT_INIT;
                            state   <= WAIT;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                WAIT: begin
                    if (!psel) begin
                        waitCnt <= '0;
                        state   <= IDLE;
                    end else if (waitCnt == 4'd1) begin
                        pready  <= 1'b1;
                        prdata  <= waitRdata;
                        pslverr <= latErr;
                        waitCnt <= '0;
                        state   <= DONE;
                    end else begin
                        waitCnt <= waitCnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_regbank_slave.sv
// Directed bench for apb_regbank_slave: three instances with 0, 2 and 3 wait states.
// Byte-strobe checks are compiled in when APB_SLV_PSTRB_EN is defined.
module tb_apb_regbank_slave;

    logic        pclk = 1'b0;
    logic [2:0]  presetn;
    logic [2:0]  psel;
    logic [2:0]  penable;
    logic        pwrite;
    logic [7:0]  paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pready;
    logic [2:0]  pslverr;
    logic [31:0] prdata [3];

    int compareCount = 0;
    int failCount    = 0;
    int cycleCount   = 0;

    always #5 pclk = ~pclk;

    always @(posedge pclk) cycleCount++;

    apb_regbank_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .NUM_REGS(16), .WAIT_STATES(0)) u0 (
        .pclk(pclk), .presetn(presetn[0]), .psel(psel[0]), .penable(penable[0]),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
`ifdef APB_SLV_PSTRB_EN
        .pstrb(pstrb),
`endif
        .pready(pready[0]), .prdata(prdata[0]), .pslverr(pslverr[0]));

    apb_regbank_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .NUM_REGS(16), .WAIT_STATES(2)) u1 (
        .pclk(pclk), .presetn(presetn[1]), .psel(psel[1]), .penable(penable[1]),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
`ifdef APB_SLV_PSTRB_EN
        .pstrb(pstrb),
`endif
        .pready(pready[1]), .prdata(prdata[1]), .pslverr(pslverr[1]));

    apb_regbank_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .NUM_REGS(16), .WAIT_STATES(3)) u2 (
        .pclk(pclk), .presetn(presetn[2]), .psel(psel[2]), .penable(penable[2]),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
`ifdef APB_SLV_PSTRB_EN
        .pstrb(pstrb),
`endif
        .pready(pready[2]), .prdata(prdata[2]), .pslverr(pslverr[2]));

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // One full APB transfer starting at posedge+1; leaves the bus idle at posedge+1.
    task automatic applyStimulus(input string tag, input int d, input logic wr,
                                 input logic [7:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] strb, output logic [31:0] rdata,
                                 output logic err, output int accCycles, output int startCycle);
        startCycle = cycleCount;
        psel[d]    = 1'b1;
        penable[d] = 1'b0;
        pwrite     = wr;
        paddr      = addr;
        pwdata     = wdata;
        pstrb      = strb;
        @(posedge pclk); #1;
        penable[d] = 1'b1;
        accCycles  = 0;
        while (1) begin
            @(negedge pclk);
            accCycles++;
            if (pready[d] === 1'b1 || accCycles >= 40) break;
            @(posedge pclk); #1;
        end
        checkOutput({tag, " pready seen"}, {31'b0, pready[d]}, 32'd1);
        rdata = prdata[d];
        err   = pslverr[d];
        @(posedge pclk); #1;
        psel[d]    = 1'b0;
        penable[d] = 1'b0;
        checkOutput({tag, " pready/pslverr drop"}, {30'b0, pready[d], pslverr[d]}, 32'd0);
        checkOutput({tag, " prdata drop"}, prdata[d], 32'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        logic        err;
        int          acc;
        int          st;
        int          st2;
        logic        sawReady;

        presetn = 3'b000;
        psel    = 3'b000;
        penable = 3'b000;
        pwrite  = 1'b0;
        paddr   = 8'h00;
        pwdata  = 32'h0;
        pstrb   = 4'h0;
        #1;
        checkOutput("reset pready", {31'b0, pready[0]}, 32'd0);
        checkOutput("reset pslverr", {31'b0, pslverr[0]}, 32'd0);
        checkOutput("reset prdata", prdata[0], 32'd0);
        repeat (3) @(posedge pclk);
        #1;
        presetn = 3'b111;
        @(posedge pclk); #1;

        $display("[TB] read after reset");
        applyStimulus("rd 0x0C", 0, 1'b0, 8'h0C, 32'h0, 4'hF, rd, err, acc, st);
        checkOutput("rd 0x0C data", rd, 32'h0000_0000);
        checkOutput("rd 0x0C err", {31'b0, err}, 32'd0);
        checkOutput("rd 0x0C latency", 32'(acc), 32'd1);

        $display("[TB] back-to-back write/read");
        applyStimulus("wr 0x08", 0, 1'b1, 8'h08, 32'hDEAD_BEEF, 4'hF, rd, err, acc, st);
        checkOutput("wr 0x08 err", {31'b0, err}, 32'd0);
        checkOutput("wr 0x08 latency", 32'(acc), 32'd1);
        applyStimulus("rd 0x08", 0, 1'b0, 8'h08, 32'h0, 4'hF, rd, err, acc, st2);
        checkOutput("rd 0x08 data", rd, 32'hDEAD_BEEF);
        checkOutput("rd 0x08 latency", 32'(acc), 32'd1);
        checkOutput("b2b spacing", 32'(st2 - st), 32'd2);

        $display("[TB] error accesses");
        applyStimulus("wr 0x40", 0, 1'b1, 8'h40, 32'hFFFF_FFFF, 4'hF, rd, err, acc, st);
        checkOutput("wr 0x40 err", {31'b0, err}, 32'd1);
        applyStimulus("wr 0x09", 0, 1'b1, 8'h09, 32'h0BAD_0BAD, 4'hF, rd, err, acc, st);
        checkOutput("wr 0x09 err", {31'b0, err}, 32'd1);
        applyStimulus("rd 0x40", 0, 1'b0, 8'h40, 32'h0, 4'hF, rd, err, acc, st);
        checkOutput("rd 0x40 err", {31'b0, err}, 32'd1);
        checkOutput("rd 0x40 data", rd, 32'h0);
        applyStimulus("rd 0x08 again", 0, 1'b0, 8'h08, 32'h0, 4'hF, rd, err, acc, st);
        checkOutput("rd 0x08 kept", rd, 32'hDEAD_BEEF);
        checkOutput("rd 0x08 kept err", {31'b0, err}, 32'd0);
        applyStimulus("rd 0x00", 0, 1'b0, 8'h00, 32'h0, 4'hF, rd, err, acc, st);
        checkOutput("rd 0x00 kept", rd, 32'h0);
        applyStimulus("rd 0x3C", 0, 1'b0, 8'h3C, 32'h0, 4'hF, rd, err, acc, st);
        checkOutput("rd 0x3C last reg err", {31'b0, err}, 32'd0);
        checkOutput("rd 0x3C last reg data", rd, 32'h0);

        $display("[TB] two wait states");
        applyStimulus("ws2 wr 0x04", 1, 1'b1, 8'h04, 32'h1234_5678, 4'hF, rd, err, acc, st);
        checkOutput("ws2 wr latency", 32'(acc), 32'd3);
        checkOutput("ws2 wr err", {31'b0, err}, 32'd0);
        applyStimulus("ws2 rd 0x04", 1, 1'b0, 8'h04, 32'h0, 4'hF, rd, err, acc, st);
        checkOutput("ws2 rd data", rd, 32'h1234_5678);
        checkOutput("ws2 rd latency", 32'(acc), 32'd3);

`ifdef APB_SLV_PSTRB_EN
        $display("[TB] byte strobes");
        applyStimulus("strb init", 0, 1'b1, 8'h00, 32'h1122_3344, 4'hF, rd, err, acc, st);
        applyStimulus("strb 0101", 0, 1'b1, 8'h00, 32'hAABB_CCDD, 4'b0101, rd, err, acc, st);
        applyStimulus("strb rd1", 0, 1'b0, 8'h00, 32'h0, 4'h0, rd, err, acc, st);
        checkOutput("strb 0101 data", rd, 32'h11BB_33DD);
        applyStimulus("strb 0000", 0, 1'b1, 8'h00, 32'h5555_5555, 4'b0000, rd, err, acc, st);
        checkOutput("strb 0000 err", {31'b0, err}, 32'd0);
        applyStimulus("strb rd2", 0, 1'b0, 8'h00, 32'h0, 4'h0, rd, err, acc, st);
        checkOutput("strb 0000 data", rd, 32'h11BB_33DD);
`else
        $display("[TB] full-word writes");
        applyStimulus("full wr", 0, 1'b1, 8'h00, 32'h1122_3344, 4'b0101, rd, err, acc, st);
        applyStimulus("full rd", 0, 1'b0, 8'h00, 32'h0, 4'h0, rd, err, acc, st);
        checkOutput("full word data", rd, 32'h1122_3344);
`endif

        $display("[TB] three wait states, reset and abort");
        applyStimulus("ws3 wr 0x08", 2, 1'b1, 8'h08, 32'hCAFE_F00D, 4'hF, rd, err, acc, st);
        checkOutput("ws3 wr latency", 32'(acc), 32'd4);
        applyStimulus("ws3 rd 0x08", 2, 1'b0, 8'h08, 32'h0, 4'hF, rd, err, acc, st);
        checkOutput("ws3 rd data", rd, 32'hCAFE_F00D);

        psel[2]    = 1'b1;
        penable[2] = 1'b0;
        pwrite     = 1'b1;
        paddr      = 8'h00;
        pwdata     = 32'hA5A5_A5A5;
        pstrb      = 4'hF;
        @(posedge pclk); #1;
        penable[2] = 1'b1;
        @(posedge pclk); #1;
        @(negedge pclk);
        presetn[2] = 1'b0;
        #1;
        checkOutput("reset mid-wait pready", {31'b0, pready[2]}, 32'd0);
        @(posedge pclk); #1;
        psel[2]    = 1'b0;
        penable[2] = 1'b0;
        presetn[2] = 1'b1;
        @(posedge pclk); #1;
        applyStimulus("ws3 rd 0x00 after reset", 2, 1'b0, 8'h00, 32'h0, 4'hF, rd, err, acc, st);
        checkOutput("reset mid-wait reg 0x00", rd, 32'h0);
        applyStimulus("ws3 rd 0x08 after reset", 2, 1'b0, 8'h08, 32'h0, 4'hF, rd, err, acc, st);
        checkOutput("reset clears reg 0x08", rd, 32'h0);

        sawReady   = 1'b0;
        psel[2]    = 1'b1;
        penable[2] = 1'b0;
        pwrite     = 1'b1;
        paddr      = 8'h00;
        pwdata     = 32'h5A5A_5A5A;
        @(posedge pclk); #1;
        penable[2] = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge pclk);
            if (pready[2] !== 1'b0) sawReady = 1'b1;
            @(posedge pclk); #1;
        end
        psel[2]    = 1'b0;
        penable[2] = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge pclk);
            if (pready[2] !== 1'b0) sawReady = 1'b1;
        end
        @(posedge pclk); #1;
        checkOutput("abort no pready", {31'b0, sawReady}, 32'd0);
        applyStimulus("ws3 rd after abort", 2, 1'b0, 8'h00, 32'h0, 4'hF, rd, err, acc, st);
        checkOutput("abort no write", rd, 32'h0);
        applyStimulus("ws3 wr after abort", 2, 1'b1, 8'h00, 32'h0000_BEEF, 4'hF, rd, err, acc, st);
        checkOutput("post-abort wr latency", 32'(acc), 32'd4);
        applyStimulus("ws3 rd final", 2, 1'b0, 8'h00, 32'h0, 4'hF, rd, err, acc, st);
        checkOutput("post-abort rd data", rd, 32'h0000_BEEF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
